// File: rtl/frag_merge_fifo.sv
// frag_merge_fifo: merges rast's dual sample hits into one in-order fragment stream,
// buffered in a FIFO whose registered halt leaves room for rast's in-flight hits.
module frag_merge_fifo #(
    parameter int SIGFIG = 24,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int DEPTH  = 16,
    parameter int SKID   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SIGFIG*AXIS-1:0]     hit_R18S,
    input  logic                       hit_valid_R18H,
    input  logic [SIGFIG*AXIS-1:0]     hit_R18S_2,
    input  logic                       hit_valid_R18H_2,
    input  logic [SIGFIG*COLORS-1:0]   color_R18U,
    output logic                       halt_RnnnnL,
    output logic [SIGFIG*AXIS-1:0]     frag_S,
    output logic [SIGFIG*COLORS-1:0]   frag_color_U,
    output logic                       frag_valid_H,
    input  logic                       frag_ready_H,
    output logic [$clog2(DEPTH+1)-1:0] count_U,
    output logic                       overflow_H
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int LW = SIGFIG*AXIS;
    localparam int KW = SIGFIG*COLORS;

    logic [LW+KW-1:0] mem [DEPTH];
    logic [LW+KW-1:0] head;
    logic [PW-1:0]    wptr, rptr, wptr_b;
    logic [CW:0]      avail;
    logic [CW-1:0]    count_nxt;
    logic             pop, a_wr, b_wr, drop;

    assign frag_valid_H = count_U != '0;
    assign pop          = frag_valid_H & frag_ready_H;
    // a pop in this cycle frees a slot that a same-cycle write may reuse
    assign avail        = (CW+1)'(DEPTH) - {1'b0, count_U} + {{CW{1'b0}}, pop};
    assign a_wr         = hit_valid_R18H & (avail != '0);
    assign b_wr         = hit_valid_R18H_2 & (avail > {{CW{1'b0}}, a_wr});
    assign drop         = (hit_valid_R18H & ~a_wr) | (hit_valid_R18H_2 & ~b_wr);
    assign wptr_b       = wptr + PW'(a_wr);
    assign count_nxt    = count_U + CW'(a_wr) + CW'(b_wr) - CW'(pop);
    assign head         = mem[rptr];
    assign frag_S       = frag_valid_H ? head[LW+KW-1:KW] : '0;
    assign frag_color_U = frag_valid_H ? head[KW-1:0] : '0;

    always_ff @(posedge clk) begin
        if (a_wr) mem[wptr] <= {hit_R18S, color_R18U};
        if (b_wr) mem[wptr_b] <= {hit_R18S_2, color_R18U};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count_U     <= '0;
            overflow_H  <= 1'b0;
            halt_RnnnnL <= 1'b1;
        end else begin
            wptr        <= wptr + PW'(a_wr) + PW'(b_wr);
            rptr        <= rptr + PW'(pop);
            count_U     <= count_nxt;
            overflow_H  <= overflow_H | drop;
            halt_RnnnnL <= !(((CW+1)'(DEPTH) - {1'b0, count_nxt}) < (CW+1)'(2*(SKID+1)));
        end
    end
endmodule

// File: tb/tb_frag_merge_fifo.sv
// tb_frag_merge_fifo: scoreboard bench; expected fragments are queued as hits are driven
// and compared against the FIFO head each cycle.
module tb_frag_merge_fifo;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [71:0]  hit_R18S = '0, hit_R18S_2 = '0, color_R18U = '0;
    logic         hit_valid_R18H = 1'b0, hit_valid_R18H_2 = 1'b0, frag_ready_H = 1'b0;
    logic         halt_RnnnnL, frag_valid_H, overflow_H;
    logic [71:0]  frag_S, frag_color_U;
    logic [4:0]   count_U;

    logic [143:0] q[$];
    logic         halt_exp = 1'b1, ovf_exp = 1'b0;
    int           vectors = 0, errs = 0;

    frag_merge_fifo dut (
        .clk(clk), .rst(rst),
        .hit_R18S(hit_R18S), .hit_valid_R18H(hit_valid_R18H),
        .hit_R18S_2(hit_R18S_2), .hit_valid_R18H_2(hit_valid_R18H_2),
        .color_R18U(color_R18U), .halt_RnnnnL(halt_RnnnnL),
        .frag_S(frag_S), .frag_color_U(frag_color_U),
        .frag_valid_H(frag_valid_H), .frag_ready_H(frag_ready_H),
        .count_U(count_U), .overflow_H(overflow_H)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] rnd72();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic step(input logic va, input logic vb, input logic [71:0] a, input logic [71:0] b,
                        input logic [71:0] col, input logic rdy);
        int  avail;
        logic pop;
        @(negedge clk);
        chk("valid", 144'(frag_valid_H), 144'(q.size() != 0));
        chk("count", 144'(count_U), 144'(q.size()));
        chk("halt", 144'(halt_RnnnnL), 144'(halt_exp));
        chk("overflow", 144'(overflow_H), 144'(ovf_exp));
        if (q.size() != 0) begin
            chk("frag_S", 144'(frag_S), 144'(q[0][143:72]));
            chk("frag_color", 144'(frag_color_U), 144'(q[0][71:0]));
        end
        pop   = (q.size() != 0) && rdy;
        avail = 16 - q.size() + int'(pop);
        if (pop) void'(q.pop_front());
        if (va) begin
            if (avail > 0) begin q.push_back({a, col}); avail--; end
            else ovf_exp = 1'b1;
        end
        if (vb) begin
            if (avail > 0) q.push_back({b, col});
            else ovf_exp = 1'b1;
        end
        halt_exp = !((16 - q.size()) < 6);
        hit_valid_R18H   = va;
        hit_valid_R18H_2 = vb;
        hit_R18S         = a;
        hit_R18S_2       = b;
        color_R18U       = col;
        frag_ready_H     = rdy;
        @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, rnd72(), rnd72(), rnd72(), 1);
        // dual hit into an empty FIFO, drained in A-then-B order
        step(1, 1, {24'd1, 24'd7, 24'd5}, {24'd1, 24'd7, 24'd6}, {24'h10, 24'h0, 24'hFF}, 1);
        repeat (3) step(0, 0, rnd72(), rnd72(), rnd72(), 1);
        // backpressure fill to 16 with no drops
        for (int i = 0; i < 8; i++) step(1, 1, rnd72(), rnd72(), rnd72(), 0);
        step(0, 0, rnd72(), rnd72(), rnd72(), 1);
        // at 15 entries a dual hit keeps A and drops B
        step(1, 1, rnd72(), rnd72(), rnd72(), 0);
        step(0, 0, rnd72(), rnd72(), rnd72(), 0);
        // full with pop and a single write in the same cycle
        step(1, 0, rnd72(), rnd72(), rnd72(), 1);
        repeat (7) step(0, 0, rnd72(), rnd72(), rnd72(), 1);
        step(0, 0, rnd72(), rnd72(), rnd72(), 0);
        chk("count_before_reset", 144'(count_U), 144'(9));
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", 144'(frag_valid_H), 144'(0));
        chk("rst_count", 144'(count_U), 144'(0));
        chk("rst_halt", 144'(halt_RnnnnL), 144'(1));
        chk("rst_overflow", 144'(overflow_H), 144'(0));
        chk("rst_frag_S", 144'(frag_S), 144'(0));
        q.delete();
        halt_exp = 1'b1;
        ovf_exp  = 1'b0;
        hit_valid_R18H   = 1'b0;
        hit_valid_R18H_2 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step(0, 0, rnd72(), rnd72(), rnd72(), 1);
        for (int i = 0; i < 200; i++)
            step(1'($urandom), 1'($urandom), rnd72(), rnd72(), rnd72(), 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), rnd72(), rnd72(), rnd72(), 1'($urandom_range(0, 4) == 0));
        repeat (20) step(0, 0, rnd72(), rnd72(), rnd72(), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
